// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared types and default widths for the GPR SRAM access controller.
//   regfile_state_e : controller FSM states (INIT sweep, RUN).
//   regfile_lw_t    : last-write record used by the bypass network.
// The last-write record is sized by the package default widths; the top-level
// parameters default to the same values.
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int unsigned REGFILE_BUS_WIDTH  = 8;
    localparam int unsigned REGFILE_ADDR_WIDTH = 3;

    typedef enum logic {
        INIT,
        RUN
    } regfile_state_e;

    typedef struct packed {
        logic                          valid;
        logic [REGFILE_ADDR_WIDTH-1:0] addr;
        logic [REGFILE_BUS_WIDTH-1:0]  data;
    } regfile_lw_t;

endpackage

// File: rtl/regfile_bypass.sv
// -----------------------------------------------------------------------------
// regfile_bypass
// Combinational operand-select mux for one read port of the GPR SRAM.
// Priority: same-cycle writeback, then last-cycle write, then SRAM data.
// Optional macro REGFILE_ZERO_REG_EN: index 0 always reads as zero.
// Ports:
//   i_rs           : source index held in the read stage
//   i_wb_fire      : writeback accepted this cycle
//   i_wb_addr      : writeback index
//   i_wb_data      : writeback data
//   i_lw           : write committed to the SRAM on the previous edge
//   i_sram_rd_data : registered SRAM read data for this port
//   o_operand      : selected operand
// -----------------------------------------------------------------------------
module regfile_bypass
    import regfile_pkg::*;
#(
    parameter int unsigned BUS_WIDTH  = REGFILE_BUS_WIDTH,
    parameter int unsigned ADDR_WIDTH = REGFILE_ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] i_rs,
    input  logic                  i_wb_fire,
    input  logic [ADDR_WIDTH-1:0] i_wb_addr,
    input  logic [BUS_WIDTH-1:0]  i_wb_data,
    input  regfile_lw_t           i_lw,
    input  logic [BUS_WIDTH-1:0]  i_sram_rd_data,
    output logic [BUS_WIDTH-1:0]  o_operand
);

    always_comb begin
        o_operand = i_sram_rd_data;
        if (i_wb_fire && (i_wb_addr == i_rs)) begin
            o_operand = i_wb_data;
        end else if (i_lw.valid && (i_lw.addr == i_rs)) begin
            // SRAM returned pre-write data for a read that coincided with this write
            o_operand = i_lw.data;
        end
`ifdef REGFILE_ZERO_REG_EN
        if (i_rs == '0) begin
            o_operand = '0;
        end
`endif
    end

endmodule

// File: rtl/regfile_access_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_access_ctrl
// Initiator-side controller for a 2-read/1-write synchronous-read GPR SRAM.
// After reset it sweeps every entry to zero (INIT), then serves operand-read
// requests through a single-entry read stage (S1) and passes writebacks to the
// SRAM. A bypass network hides the 1-cycle read latency and the SRAM's
// read-old-data-on-write behaviour.
// Optional macro REGFILE_ZERO_REG_EN: index 0 hardwired to zero (writes to it
// are accepted but dropped; reads return zero).
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   i_req_valid/o_req_ready        : operand-read request handshake
//   i_req_rs_a/i_req_rs_b          : source indices
//   o_op_valid/i_op_ready          : operand handshake
//   o_op_a/o_op_b                  : operands
//   i_wb_valid/o_wb_ready          : writeback handshake
//   i_wb_addr/i_wb_data            : writeback index and data
//   o_sram_we/o_sram_wr_addr/o_sram_wr_data : SRAM write port
//   o_sram_rd_addr_a/b             : SRAM read addresses
//   i_sram_rd_data_a/b             : SRAM registered read data
// -----------------------------------------------------------------------------
module regfile_access_ctrl
    import regfile_pkg::*;
#(
    parameter int unsigned BUS_WIDTH  = REGFILE_BUS_WIDTH,
    parameter int unsigned ADDR_WIDTH = REGFILE_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_req_rs_a,
    input  logic [ADDR_WIDTH-1:0] i_req_rs_b,
    output logic                  o_op_valid,
    input  logic                  i_op_ready,
    output logic [BUS_WIDTH-1:0]  o_op_a,
    output logic [BUS_WIDTH-1:0]  o_op_b,
    input  logic                  i_wb_valid,
    output logic                  o_wb_ready,
    input  logic [ADDR_WIDTH-1:0] i_wb_addr,
    input  logic [BUS_WIDTH-1:0]  i_wb_data,
    output logic                  o_sram_we,
    output logic [ADDR_WIDTH-1:0] o_sram_wr_addr,
    output logic [BUS_WIDTH-1:0]  o_sram_wr_data,
    output logic [ADDR_WIDTH-1:0] o_sram_rd_addr_a,
    output logic [ADDR_WIDTH-1:0] o_sram_rd_addr_b,
    input  logic [BUS_WIDTH-1:0]  i_sram_rd_data_a,
    input  logic [BUS_WIDTH-1:0]  i_sram_rd_data_b
);

    localparam int unsigned            N        = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0]  LAST_IDX = ADDR_WIDTH'(N - 1);

    regfile_state_e          r_state;
    logic [ADDR_WIDTH-1:0]   r_init_cnt;
    logic                    r_s1_valid;
    logic [ADDR_WIDTH-1:0]   r_s1_rs_a;
    logic [ADDR_WIDTH-1:0]   r_s1_rs_b;
    regfile_lw_t             r_lw;

    logic                    w_run;
    logic                    w_wb_fire;
    logic                    w_wb_wr;
    logic                    w_accept;

    assign w_run     = (r_state == RUN);
    assign w_wb_fire = i_wb_valid && w_run;
`ifdef REGFILE_ZERO_REG_EN
    // Writes to index 0 are handshaken but never reach the SRAM or bypass
    assign w_wb_wr   = w_wb_fire && (i_wb_addr != '0);
`else
    assign w_wb_wr   = w_wb_fire;
`endif

    assign o_req_ready = w_run && (!r_s1_valid || i_op_ready);
    assign o_wb_ready  = w_run;
    assign w_accept    = i_req_valid && o_req_ready;
    assign o_op_valid  = r_s1_valid;

    // INIT (including while held in reset) writes zero to the sweep index
    assign o_sram_we      = w_run ? w_wb_wr   : 1'b1;
    assign o_sram_wr_addr = w_run ? i_wb_addr : r_init_cnt;
    assign o_sram_wr_data = w_run ? i_wb_data : '0;

    // While stalled, keep re-reading the S1 indices so SRAM data stays current
    assign o_sram_rd_addr_a = w_accept ? i_req_rs_a : r_s1_rs_a;
    assign o_sram_rd_addr_b = w_accept ? i_req_rs_b : r_s1_rs_b;

    // Controller FSM: INIT sweep of N entries, then RUN until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= INIT;
            r_init_cnt <= '0;
        end else begin
            unique case (r_state)
                INIT: begin
                    r_init_cnt <= r_init_cnt + 1'b1;
                    if (r_init_cnt == LAST_IDX) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_state <= RUN;
                end
                default: begin
                    r_state <= INIT;
                end
            endcase
        end
    end

    // Single-entry read stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_rs_a  <= '0;
            r_s1_rs_b  <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_rs_a  <= i_req_rs_a;
            r_s1_rs_b  <= i_req_rs_b;
        end else if (i_op_ready) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Last write seen by the SRAM, captured every edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lw <= '0;
        end else begin
            r_lw.valid <= w_wb_wr;
            r_lw.addr  <= i_wb_addr;
            r_lw.data  <= i_wb_data;
        end
    end

    regfile_bypass #(
        .BUS_WIDTH  (BUS_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bypass_a (
        .i_rs           (r_s1_rs_a),
        .i_wb_fire      (w_wb_fire),
        .i_wb_addr      (i_wb_addr),
        .i_wb_data      (i_wb_data),
        .i_lw           (r_lw),
        .i_sram_rd_data (i_sram_rd_data_a),
        .o_operand      (o_op_a)
    );

    regfile_bypass #(
        .BUS_WIDTH  (BUS_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bypass_b (
        .i_rs           (r_s1_rs_b),
        .i_wb_fire      (w_wb_fire),
        .i_wb_addr      (i_wb_addr),
        .i_wb_data      (i_wb_data),
        .i_lw           (r_lw),
        .i_sram_rd_data (i_sram_rd_data_b),
        .o_operand      (o_op_b)
    );

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_regfile_access_ctrl
// Directed bench for regfile_access_ctrl with a behavioural 2R1W SRAM that
// returns old data on a same-edge read/write. Expected operands are queued when
// a request is issued and compared by a monitor whenever an operand is taken.
// Build with +define+REGFILE_ZERO_REG_EN to exercise the zero-register option.
// -----------------------------------------------------------------------------
module tb_regfile_access_ctrl;

    localparam int BW = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid, req_ready, op_valid, op_ready;
    logic [AW-1:0] req_rs_a, req_rs_b, wb_addr;
    logic [BW-1:0] op_a, op_b, wb_data;
    logic          wb_valid, wb_ready, sram_we;
    logic [AW-1:0] sram_wr_addr, sram_rd_addr_a, sram_rd_addr_b;
    logic [BW-1:0] sram_wr_data, sram_rd_data_a, sram_rd_data_b;

    always #5 clk = ~clk;

    regfile_access_ctrl #(
        .BUS_WIDTH  (BW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_req_valid      (req_valid),
        .o_req_ready      (req_ready),
        .i_req_rs_a       (req_rs_a),
        .i_req_rs_b       (req_rs_b),
        .o_op_valid       (op_valid),
        .i_op_ready       (op_ready),
        .o_op_a           (op_a),
        .o_op_b           (op_b),
        .i_wb_valid       (wb_valid),
        .o_wb_ready       (wb_ready),
        .i_wb_addr        (wb_addr),
        .i_wb_data        (wb_data),
        .o_sram_we        (sram_we),
        .o_sram_wr_addr   (sram_wr_addr),
        .o_sram_wr_data   (sram_wr_data),
        .o_sram_rd_addr_a (sram_rd_addr_a),
        .o_sram_rd_addr_b (sram_rd_addr_b),
        .i_sram_rd_data_a (sram_rd_data_a),
        .i_sram_rd_data_b (sram_rd_data_b)
    );

    // Synchronous-read SRAM: a read on the write edge returns the old contents
    logic [BW-1:0] mem [2**AW];
    always @(posedge clk) begin
        if (sram_we) mem[sram_wr_addr] <= sram_wr_data;
        sram_rd_data_a <= mem[sram_rd_addr_a];
        sram_rd_data_b <= mem[sram_rd_addr_b];
    end

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [BW-1:0] a;
        logic [BW-1:0] b;
    } exp_t;
    exp_t sb_q[$];

`ifdef REGFILE_ZERO_REG_EN
    localparam logic       ZR_WE  = 1'b0;
    localparam logic [7:0] ZR_VAL = 8'h00;
`else
    localparam logic       ZR_WE  = 1'b1;
    localparam logic [7:0] ZR_VAL = 8'hFF;
`endif

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: compare every operand the consumer takes against the queue
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && op_valid && op_ready) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL op_unexpected: got op_a=0x%0h op_b=0x%0h, expected none",
                         op_a, op_b);
            end else begin
                e = sb_q.pop_front();
                chk("op_a", 32'(op_a), 32'(e.a));
                chk("op_b", 32'(op_b), 32'(e.b));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_wb(input logic [AW-1:0] a, input logic [BW-1:0] d);
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        step();
        wb_valid = 1'b0;
    endtask

    task automatic set_req(input logic [AW-1:0] a, input logic [AW-1:0] b);
        req_valid = 1'b1;
        req_rs_a  = a;
        req_rs_b  = b;
    endtask

    task automatic check_init_sweep(input string tag);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk({tag, "_we"},       32'(sram_we),      32'd1);
            chk({tag, "_addr"},     32'(sram_wr_addr), 32'(i));
            chk({tag, "_data"},     32'(sram_wr_data), 32'd0);
            chk({tag, "_req_rdy"},  32'(req_ready),    32'd0);
            chk({tag, "_wb_rdy"},   32'(wb_ready),     32'd0);
        end
        @(negedge clk);
        chk({tag, "_run_req_rdy"}, 32'(req_ready), 32'd1);
        chk({tag, "_run_wb_rdy"},  32'(wb_ready),  32'd1);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        req_valid = 1'b0; req_rs_a = '0; req_rs_b = '0;
        wb_valid  = 1'b0; wb_addr  = '0; wb_data  = '0;
        op_ready  = 1'b1;

        // Reset outputs
        #3;
        chk("rst_we",       32'(sram_we),      32'd1);
        chk("rst_wr_addr",  32'(sram_wr_addr), 32'd0);
        chk("rst_wr_data",  32'(sram_wr_data), 32'd0);
        chk("rst_req_rdy",  32'(req_ready),    32'd0);
        chk("rst_wb_rdy",   32'(wb_ready),     32'd0);
        chk("rst_op_valid", 32'(op_valid),     32'd0);
        step();
        rst_n = 1'b1;

        // INIT sweep: 8 zero writes, then ready
        check_init_sweep("init");
        step();

        // wb r3=A5, then read r3 on both ports two cycles later
        do_wb(3'd3, 8'hA5);
        step();
        set_req(3'd3, 3'd3);
        sb_q.push_back('{8'hA5, 8'hA5});
        step();
        req_valid = 1'b0;
        @(negedge clk);
        chk("t2_op_valid", 32'(op_valid), 32'd1);
        step();

        // Same-cycle wb r5=3C and read r5: lw bypass fixes stale SRAM data
        wb_valid = 1'b1; wb_addr = 3'd5; wb_data = 8'h3C;
        set_req(3'd5, 3'd0);
        sb_q.push_back('{8'h3C, 8'h00});
        @(negedge clk);
        chk("t3_we",      32'(sram_we),      32'd1);
        chk("t3_wr_addr", 32'(sram_wr_addr), 32'd5);
        step();
        wb_valid = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("t3_op_valid", 32'(op_valid), 32'd1);
        step();

        // Stall three cycles on rs_a=2, write r2=11 in stall cycle 2
        op_ready = 1'b0;
        set_req(3'd2, 3'd4);
        sb_q.push_back('{8'h11, 8'h00});
        step();
        req_valid = 1'b0;
        @(negedge clk);
        chk("stall1_valid",   32'(op_valid),  32'd1);
        chk("stall1_op_a",    32'(op_a),      32'h00);
        chk("stall1_req_rdy", 32'(req_ready), 32'd0);
        step();
        wb_valid = 1'b1; wb_addr = 3'd2; wb_data = 8'h11;
        @(negedge clk);
        chk("stall2_op_a",    32'(op_a),      32'h11);
        chk("stall2_req_rdy", 32'(req_ready), 32'd0);
        step();
        wb_valid = 1'b0;
        @(negedge clk);
        chk("stall3_op_a",    32'(op_a),      32'h11);
        chk("stall3_req_rdy", 32'(req_ready), 32'd0);
        step();
        op_ready = 1'b1;
        @(negedge clk);
        chk("stall_rel_req_rdy", 32'(req_ready), 32'd1);
        step();
        @(negedge clk);
        chk("stall_drained", 32'(op_valid), 32'd0);
        step();

        // r1..r6 = 10..60, then six back-to-back reads
        for (int i = 1; i <= 6; i++) do_wb(AW'(i), BW'(i * 16));
        for (int i = 1; i <= 6; i++) begin
            set_req(AW'(i), AW'(7 - i));
            sb_q.push_back('{BW'(i * 16), BW'((7 - i) * 16)});
            @(negedge clk);
            chk("b2b_req_rdy", 32'(req_ready), 32'd1);
            if (i > 1) chk("b2b_op_valid", 32'(op_valid), 32'd1);
            step();
        end
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_last_valid", 32'(op_valid), 32'd1);
        step();
        @(negedge clk);
        chk("b2b_q_empty", 32'(sb_q.size()), 32'd0);
        step();

        // Index 0 write and read
        wb_valid = 1'b1; wb_addr = 3'd0; wb_data = 8'hFF;
        @(negedge clk);
        chk("zr_we", 32'(sram_we), 32'(ZR_WE));
        step();
        wb_valid = 1'b0;
        set_req(3'd0, 3'd6);
        sb_q.push_back('{ZR_VAL, 8'h60});
        step();
        req_valid = 1'b0;
        @(negedge clk);
        chk("zr_op_valid", 32'(op_valid), 32'd1);
        step();

        // Reset with an operand held in S1: dropped, INIT restarts
        op_ready = 1'b0;
        set_req(3'd1, 3'd1);
        step();
        req_valid = 1'b0;
        @(negedge clk);
        chk("mid_op_valid", 32'(op_valid), 32'd1);
        step();
        rst_n = 1'b0;
        #1;
        chk("rst2_op_valid", 32'(op_valid),     32'd0);
        chk("rst2_we",       32'(sram_we),      32'd1);
        chk("rst2_wr_addr",  32'(sram_wr_addr), 32'd0);
        chk("rst2_req_rdy",  32'(req_ready),    32'd0);
        op_ready = 1'b1;
        step();
        rst_n = 1'b1;
        check_init_sweep("reinit");
        step();
        set_req(3'd3, 3'd1);
        sb_q.push_back('{8'h00, 8'h00});
        step();
        req_valid = 1'b0;
        @(negedge clk);
        chk("reinit_op_valid", 32'(op_valid), 32'd1);
        step();
        step();

        chk("final_q_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
- Initiator-side controller for the 2-read/1-write synchronous-read GPR SRAM.
- Accepts operand-read requests and writeback requests, and drives the SRAM address, write-enable and write-data pins.
- Hides the SRAM's 1-cycle read latency and its read-old-data-on-write behaviour using a bypass network.
- Clears the SRAM after reset with an INIT sweep, so no simulation-only initialisation is needed.

Parameters:
- BUS_WIDTH, 8, GPR data width.
- ADDR_WIDTH, 3, GPR index width; N = 2**ADDR_WIDTH entries.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  operand-read request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_rs_a  in  ADDR_WIDTH  source index A.
- req_rs_b  in  ADDR_WIDTH  source index B.
- op_valid  out  1  operands valid.
- op_ready  in  1  consumer accepts operands.
- op_a  out  BUS_WIDTH  operand A.
- op_b  out  BUS_WIDTH  operand B.
- wb_valid  in  1  writeback valid.
- wb_ready  out  1  writeback accepted (wb_fire = wb_valid && wb_ready).
- wb_addr  in  ADDR_WIDTH  writeback index.
- wb_data  in  BUS_WIDTH  writeback data.
- sram_we  out  1  SRAM write enable.
- sram_wr_addr  out  ADDR_WIDTH  SRAM write address.
- sram_wr_data  out  BUS_WIDTH  SRAM write data.
- sram_rd_addr_a  out  ADDR_WIDTH  SRAM read address A.
- sram_rd_addr_b  out  ADDR_WIDTH  SRAM read address B.
- sram_rd_data_a  in  BUS_WIDTH  SRAM read data A, registered in SRAM.
- sram_rd_data_b  in  BUS_WIDTH  SRAM read data B, registered in SRAM.

Behaviour:
- FSM states: INIT, RUN.
- Reset (async, rst_n=0): state=INIT, init_cnt=0, s1_valid=0, lw_valid=0.
  - Outputs during reset: op_valid=0, req_ready=0, wb_ready=0, sram_we=1, sram_wr_addr=0, sram_wr_data=0 (a benign zero write).
- INIT:
  - sram_we=1, sram_wr_addr=init_cnt, sram_wr_data=0; init_cnt increments each cycle.
  - When init_cnt==N-1, the next state is RUN, so INIT lasts exactly N cycles after reset release.
  - req_ready=0, wb_ready=0 throughout.
- RUN:
  - wb_ready=1.
  - sram_we=wb_fire, sram_wr_addr=wb_addr, sram_wr_data=wb_data (combinational pass-through).
  - Last-write register captures on every edge: lw_valid<=wb_fire, lw_addr<=wb_addr, lw_data<=wb_data.
- Read stage S1 (single entry):
  - req_ready = RUN && (!s1_valid || op_ready).
  - On request accept, s1_valid<=1 and s1_rs_a/b<=req_rs_a/b. If op_ready consumes S1 with no new request, s1_valid<=0.
- Read addresses:
  - sram_rd_addr_x = accept ? req_rs_x : s1_rs_x.
  - While stalled, the SRAM therefore re-reads the S1 indices every cycle.
- Latency: request accepted at edge k → op_valid in the cycle after edge k. Throughput is 1 per cycle; order is preserved.
- op_valid = s1_valid.
- Operand selection, per port x, in priority order:
  1. if wb_fire && wb_addr==s1_rs_x → wb_data (same-cycle bypass);
  2. else if lw_valid && lw_addr==s1_rs_x → lw_data (covers SRAM read-during-write returning old data);
  3. else sram_rd_data_x.
- op_a/op_b are don't-care when op_valid=0; the bench checks them only while op_valid=1.
- Boundary cases:
  - Same-cycle wb and req to the same index: the request reads old SRAM data, and the lw bypass corrects it in the next cycle.
  - Writes during an op stall update the presented operand from the wb_fire cycle onward.
  - rs_a==rs_b is legal.
  - Reset mid-operation drops the in-flight operand and restarts INIT.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined: index 0 is hardwired to zero.
  - op_x forced to 0 when s1_rs_x==0, regardless of bypass.
  - A wb to index 0 is accepted (wb_ready=1) but sram_we=0 and lw_valid<=0.
  - INIT is unchanged.
- Undefined: index 0 is an ordinary register.

Decomposition:
- Package regfile_pkg:
  - regfile_state_e enum {INIT, RUN};
  - default BUS_WIDTH/ADDR_WIDTH localparams;
  - typedef for the lw record (valid, addr, data).
- Sub-module regfile_bypass: purely combinational priority mux for one port (s1_rs, wb_fire/addr/data, lw record, sram_rd_data → operand). Instantiated twice.

Test Plan:
- Reset release, N=8 → sram_we=1 with addr 0..7 and data 0 for 8 cycles; req_ready=wb_ready=0 during that window; both 1 in cycle 9.
- wb r3=0xA5, then req rs_a=3, rs_b=3 two cycles later → op_valid=1 the next cycle with op_a=op_b=0xA5.
- wb r5=0x3C and req rs_a=5 in the same cycle → next cycle op_a=0x3C (lw bypass, SRAM returns 0x00).
- op_ready=0 for 3 cycles with s1_rs_a=2, wb r2=0x11 in stall cycle 2 → op_a=0x11 from that cycle on; req_ready=0 throughout; op accepted once op_ready=1.
- 6 back-to-back requests with op_ready=1 after writing r1..r6=0x10..0x60 → one op per cycle, in order, values 0x10..0x60.
- REGFILE_ZERO_REG_EN: wb r0=0xFF → sram_we=0; read rs_a=0 → op_a=0x00. Without the macro: op_a=0xFF.
